// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake,
// and selects the next PC from execute results at exec_done.
module ifetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                Zero,
    input  logic [31:0]         Addr_result,
    input  logic [31:0]         Read_data_1,
    input  logic                Branch,
    input  logic                nBranch,
    input  logic                Jmp,
    input  logic                Jal,
    input  logic                Jr,
    output logic [PC_WIDTH-1:0] link_addr,
    output logic                misalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                run_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         instr_q;
    logic [PC_WIDTH-1:0] link_q;
    logic                misalign_q;

    logic                capture;
    logic                retire;
    logic [PC_WIDTH-1:0] pc4;
    logic [PC_WIDTH-1:0] next_pc;
    logic                take_br;

    assign pc4     = pc_q + PC_WIDTH'(4);
    assign take_br = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        next_pc = pc4;
        priority case (1'b1)
            Jr:         next_pc = {Read_data_1[PC_WIDTH-1:2], 2'b00};
            Jmp | Jal:  next_pc = {pc4[PC_WIDTH-1:PC_WIDTH-4],
                                   instr_q[25:0], 2'b00};
            take_br:    next_pc = {Addr_result[PC_WIDTH-3:0], 2'b00};
            default:    next_pc = pc4;
        endcase
    end

    // run_q keeps the request low for the first cycle after reset
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        capture  = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        capture = 1'b1;
                        state_d = VALID;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (exec_done) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH;
            run_q      <= 1'b0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            link_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (capture)
                instr_q <= imem_rdata;
            if (retire) begin
                pc_q <= next_pc;
                if (Jal)
                    link_q <= pc4;
                if (Jr && (Read_data_1[1:0] != 2'b00))
                    misalign_q <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == VALID);
    assign link_addr   = link_q;
    assign misalign    = misalign_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, Addr_result[31:30], instr_q[31:26]};

endmodule
